// File: rtl/fft8_rr_scheduler.sv
// fft8_rr_scheduler: shares one fft8_top core between NCH frame sources with round-robin grants.
// Optional RUN-phase watchdog is enabled by defining FFT8_SCHED_TIMEOUT_EN.
//
//  state | meaning
//  IDLE  | waiting for any in_valid; grants one channel and latches its frame
//  RUN   | core_start held high with the latched frame; waiting for core_done
//  OUT   | result held on the res_* port until res_ready
module fft8_rr_scheduler #(
    parameter int NCH     = 4,
    parameter int DW      = 16,
    parameter int TIMEOUT = 64,
    localparam int CHW    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NCH-1:0]        in_valid,
    output logic [NCH-1:0]        in_ready,
    input  logic [NCH*8*DW-1:0]   in_frame,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [8*DW-1:0]       res_frame,
    output logic [CHW-1:0]        res_ch,
    output logic                  busy,
    output logic                  err,
    output logic                  core_start,
    output logic [8*DW-1:0]       core_din,
    input  logic [8*DW-1:0]       core_dout,
    input  logic                  core_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_OUT
    } state_t;

    state_t           state_q, state_d;
    logic [CHW-1:0]   ptr_q, ptr_d;
    logic [CHW-1:0]   ch_q, ch_d;
    logic [8*DW-1:0]  din_d;
    logic [8*DW-1:0]  res_frame_d;
    logic [CHW-1:0]   res_ch_d;
    logic             res_valid_d;
    logic             start_d;
    logic             gnt_found;
    logic [CHW-1:0]   gnt_idx;
    logic [CHW-1:0]   scan_idx;
    int               scan_pos;

`ifdef FFT8_SCHED_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [TW-1:0] cnt_q, cnt_d;
    logic          err_d;
`endif

    // Search starts at the pointer and wraps, so the last winner has lowest priority.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_pos  = 0;
        scan_idx  = '0;
        for (int i = 0; i < NCH; i++) begin
            scan_pos = int'(ptr_q) + i;
            if (scan_pos >= NCH) scan_pos = scan_pos - NCH;
            scan_idx = CHW'(scan_pos);
            if (!gnt_found && in_valid[scan_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        ch_d        = ch_q;
        din_d       = core_din;
        res_frame_d = res_frame;
        res_ch_d    = res_ch;
        res_valid_d = res_valid;
        start_d     = core_start;
        in_ready    = '0;
`ifdef FFT8_SCHED_TIMEOUT_EN
        cnt_d       = cnt_q;
        err_d       = err;
`endif
        case (state_q)
            S_IDLE: begin
                if (gnt_found && !rst) begin
                    in_ready = NCH'(1) << gnt_idx;
                    din_d    = in_frame[gnt_idx*8*DW +: 8*DW];
                    ch_d     = gnt_idx;
                    ptr_d    = (gnt_idx == CHW'(NCH-1)) ? '0 : gnt_idx + CHW'(1);
                    start_d  = 1'b1;
                    state_d  = S_RUN;
`ifdef FFT8_SCHED_TIMEOUT_EN
                    cnt_d    = TW'(TIMEOUT-1);
`endif
                end
            end
            S_RUN: begin
                if (core_done) begin
                    res_frame_d = core_dout;
                    res_ch_d    = ch_q;
                    res_valid_d = 1'b1;
                    start_d     = 1'b0;
                    state_d     = S_OUT;
                end
`ifdef FFT8_SCHED_TIMEOUT_EN
                else if (cnt_q == '0) begin
                    err_d       = 1'b1;
                    res_frame_d = '0;
                    res_ch_d    = ch_q;
                    res_valid_d = 1'b1;
                    start_d     = 1'b0;
                    state_d     = S_OUT;
                end else begin
                    cnt_d = cnt_q - TW'(1);
                end
`endif
            end
            S_OUT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            ch_q       <= '0;
            core_din   <= '0;
            res_frame  <= '0;
            res_ch     <= '0;
            res_valid  <= 1'b0;
            core_start <= 1'b0;
`ifdef FFT8_SCHED_TIMEOUT_EN
            cnt_q      <= '0;
            err        <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            ch_q       <= ch_d;
            core_din   <= din_d;
            res_frame  <= res_frame_d;
            res_ch     <= res_ch_d;
            res_valid  <= res_valid_d;
            core_start <= start_d;
`ifdef FFT8_SCHED_TIMEOUT_EN
            cnt_q      <= cnt_d;
            err        <= err_d;
`endif
        end
    end

    assign busy = (state_q != S_IDLE);

`ifndef FFT8_SCHED_TIMEOUT_EN
    // Without the watchdog TIMEOUT has no effect; for any legal value this is constant 0.
    assign err = (TIMEOUT < 0);
`endif

endmodule

// File: tb/tb_fft8_rr_scheduler.sv
// Directed bench for fft8_rr_scheduler with a small behavioural stand-in for the fft8 core.
module tb_fft8_rr_scheduler;
    localparam int NCH = 4;
    localparam int DW  = 16;
    localparam int FW  = 8*DW;
    localparam int CHW = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_ready;
    logic [NCH*FW-1:0]    in_frame;
    logic                 res_valid;
    logic                 res_ready;
    logic [FW-1:0]        res_frame;
    logic [CHW-1:0]       res_ch;
    logic                 busy;
    logic                 err;
    logic                 core_start;
    logic [FW-1:0]        core_din;
    logic [FW-1:0]        core_dout;
    logic                 core_done;

    int n_chk  = 0;
    int n_pass = 0;

    fft8_rr_scheduler #(.NCH(NCH), .DW(DW), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_frame(in_frame),
        .res_valid(res_valid), .res_ready(res_ready), .res_frame(res_frame), .res_ch(res_ch),
        .busy(busy), .err(err),
        .core_start(core_start), .core_din(core_din), .core_dout(core_dout), .core_done(core_done)
    );

    always #5 clk = ~clk;

    // Core stand-in: reversed samples XOR 0x5A00, done pulse 4 cycles after start, waits for start low.
    function automatic logic [FW-1:0] model(input logic [FW-1:0] d);
        logic [FW-1:0] r;
        for (int k = 0; k < 8; k++) r[k*DW +: DW] = d[(7-k)*DW +: DW] ^ 16'h5A00;
        return r;
    endfunction

    function automatic logic [FW-1:0] mk(input int base);
        logic [FW-1:0] r;
        for (int k = 0; k < 8; k++) r[k*DW +: DW] = 16'(base + k);
        return r;
    endfunction

    bit            hang = 0;
    bit            inj_done = 0;
    int            m_st;
    int            m_cnt;
    logic          m_done;
    logic [FW-1:0] m_lat;
    logic [FW-1:0] m_dout;

    always @(posedge clk) begin
        if (rst) begin
            m_st <= 0; m_cnt <= 0; m_done <= 1'b0; m_dout <= '0; m_lat <= '0;
        end else begin
            m_done <= 1'b0;
            case (m_st)
                0: if (core_start && !hang) begin m_st <= 1; m_cnt <= 0; m_lat <= core_din; end
                1: if (m_cnt == 2) begin m_done <= 1'b1; m_dout <= model(m_lat); m_st <= 2; end
                   else m_cnt <= m_cnt + 1;
                2: if (!core_start) m_st <= 0;
                default: m_st <= 0;
            endcase
        end
    end

    assign core_done = m_done | inj_done;
    assign core_dout = m_dout;

    task automatic wait_res(output bit ok);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (res_valid) begin ok = 1; break; end
        end
    endtask

    task automatic do_reset();
        rst = 1; in_valid = '0; res_ready = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1; in_valid = '0; res_ready = 0; in_frame = '0;
        repeat (3) @(negedge clk);
        n_chk++;
        if (in_ready !== '0 || res_valid !== 0 || res_frame !== '0 || res_ch !== '0 ||
            busy !== 0 || err !== 0 || core_start !== 0 || core_din !== '0)
            $display("FAIL reset_state: rdy=%b rv=%b rf=%h ch=%0d busy=%b err=%b st=%b din=%h required all zero",
                     in_ready, res_valid, res_frame, res_ch, busy, err, core_start, core_din);
        else n_pass++;
        rst = 0;
        @(negedge clk);
        n_chk++;
        if (busy !== 0 || in_ready !== '0 || core_start !== 0)
            $display("FAIL reset_idle: busy=%b rdy=%b st=%b required 0/0000/0", busy, in_ready, core_start);
        else n_pass++;
    endtask

    task automatic test_single();
        logic [FW-1:0] f;
        bit ok;
        f = '0; f[15:0] = 16'd1;
        in_frame[2*FW +: FW] = f;
        in_valid = 4'b0100; #1;
        n_chk++;
        if (in_ready !== 4'b0100) $display("FAIL single_grant: in_ready=%b required 0100", in_ready);
        else n_pass++;
        @(negedge clk);
        in_valid = '0;
        n_chk++;
        if (in_ready !== '0 || busy !== 1 || core_start !== 1 || core_din !== f)
            $display("FAIL single_run: rdy=%b busy=%b st=%b din=%h required 0000/1/1/%h",
                     in_ready, busy, core_start, core_din, f);
        else n_pass++;
        wait_res(ok);
        n_chk++;
        if (!ok || res_ch !== 2'd2 || res_frame !== model(f) || core_start !== 0)
            $display("FAIL single_result: ok=%b ch=%0d frame=%h st=%b required ch2 frame=%h st=0",
                     ok, res_ch, res_frame, core_start, model(f));
        else n_pass++;
        res_ready = 1;
        @(negedge clk);
        res_ready = 0;
        n_chk++;
        if (busy !== 0 || res_valid !== 0)
            $display("FAIL single_idle: busy=%b rv=%b required 0/0", busy, res_valid);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int c = 0; c < NCH; c++) in_frame[c*FW +: FW] = mk(c*16 + 1);
        in_valid = 4'b1111; res_ready = 1;
        for (int g = 0; g < 5; g++) begin
            int exp_c;
            bit ok;
            exp_c = g % 4;
            ok = 0;
            for (int i = 0; i < 100; i++) begin
                #1;
                if (in_ready !== '0) begin ok = 1; break; end
                @(negedge clk);
            end
            n_chk++;
            if (!ok || in_ready !== (NCH'(1) << exp_c))
                $display("FAIL rr_grant%0d: in_ready=%b required %b", g, in_ready, NCH'(1) << exp_c);
            else n_pass++;
            @(negedge clk);
            wait_res(ok);
            n_chk++;
            if (!ok || res_ch !== CHW'(exp_c) || res_frame !== model(mk(exp_c*16 + 1)))
                $display("FAIL rr_result%0d: ok=%b ch=%0d frame=%h required ch%0d frame=%h",
                         g, ok, res_ch, res_frame, exp_c, model(mk(exp_c*16 + 1)));
            else n_pass++;
            @(negedge clk);
        end
        in_valid = '0; res_ready = 0;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [FW-1:0] exp_f;
        bit ok;
        in_frame[1*FW +: FW] = mk(16'h100);
        exp_f = model(mk(16'h100));
        in_valid = 4'b0010; #1;
        n_chk++;
        if (in_ready !== 4'b0010) $display("FAIL bp_grant: in_ready=%b required 0010", in_ready);
        else n_pass++;
        @(negedge clk);
        in_valid = 4'b1111;
        wait_res(ok);
        n_chk++;
        if (!ok) $display("FAIL bp_result: res_valid=%b required 1 within 200 cycles", res_valid);
        else n_pass++;
        for (int i = 0; i < 20; i++) begin
            n_chk++;
            if (res_valid !== 1 || res_ch !== 2'd1 || res_frame !== exp_f || in_ready !== '0 || core_start !== 0)
                $display("FAIL bp_hold%0d: rv=%b ch=%0d frame=%h rdy=%b st=%b required 1/1/%h/0000/0",
                         i, res_valid, res_ch, res_frame, in_ready, core_start, exp_f);
            else n_pass++;
            @(negedge clk);
        end
        res_ready = 1;
        @(negedge clk);
        res_ready = 0;
        n_chk++;
        if (busy !== 0 || res_valid !== 0 || in_ready !== 4'b0100)
            $display("FAIL bp_release: busy=%b rv=%b rdy=%b required 0/0/0100", busy, res_valid, in_ready);
        else n_pass++;
        in_valid = '0; #1;
        n_chk++;
        if (in_ready !== '0) $display("FAIL bp_drop: in_ready=%b required 0000", in_ready);
        else n_pass++;
        repeat (2) @(negedge clk);
        n_chk++;
        if (busy !== 0) $display("FAIL bp_nogrant: busy=%b required 0", busy);
        else n_pass++;
    endtask

    task automatic test_wrap();
        bit ok;
        in_frame[2*FW +: FW] = mk(16'h200);
        in_valid = 4'b0100; #1;
        n_chk++;
        if (in_ready !== 4'b0100) $display("FAIL wrap_pre: in_ready=%b required 0100", in_ready);
        else n_pass++;
        @(negedge clk);
        in_valid = '0;
        wait_res(ok);
        res_ready = 1; @(negedge clk); res_ready = 0;
        in_frame[0 +: FW] = mk(16'h300);
        in_valid = 4'b0001; #1;
        n_chk++;
        if (in_ready !== 4'b0001) $display("FAIL wrap_grant: in_ready=%b required 0001", in_ready);
        else n_pass++;
        @(negedge clk);
        in_valid = '0;
        wait_res(ok);
        n_chk++;
        if (!ok || res_ch !== 2'd0 || res_frame !== model(mk(16'h300)))
            $display("FAIL wrap_result: ok=%b ch=%0d frame=%h required ch0 frame=%h",
                     ok, res_ch, res_frame, model(mk(16'h300)));
        else n_pass++;
        res_ready = 1; @(negedge clk); res_ready = 0;
        in_valid = 4'b1111; #1;
        n_chk++;
        if (in_ready !== 4'b0010) $display("FAIL wrap_pointer: in_ready=%b required 0010", in_ready);
        else n_pass++;
        in_valid = '0;
        @(negedge clk);
    endtask

    task automatic test_stray_done();
        inj_done = 1;
        @(negedge clk);
        inj_done = 0;
        n_chk++;
        if (res_valid !== 0 || busy !== 0)
            $display("FAIL stray_done: rv=%b busy=%b required 0/0", res_valid, busy);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_timeout();
`ifdef FFT8_SCHED_TIMEOUT_EN
        int n;
        bit ok;
        hang = 1;
        in_frame[1*FW +: FW] = mk(16'h400);
        in_valid = 4'b0010;
        n = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (i == 1) in_valid = '0;
            if (res_valid) begin n = i; break; end
        end
        n_chk++;
        if (n !== 65 || err !== 1 || res_frame !== '0 || res_ch !== 2'd1 || core_start !== 0)
            $display("FAIL timeout_abort: cycles=%0d err=%b frame=%h ch=%0d st=%b required 65/1/0/1/0",
                     n, err, res_frame, res_ch, core_start);
        else n_pass++;
        res_ready = 1; @(negedge clk); res_ready = 0;
        hang = 0;
        in_frame[2*FW +: FW] = mk(16'h500);
        in_valid = 4'b0100;
        @(negedge clk);
        in_valid = '0;
        wait_res(ok);
        n_chk++;
        if (!ok || err !== 1 || res_ch !== 2'd2 || res_frame !== model(mk(16'h500)))
            $display("FAIL timeout_recover: ok=%b err=%b ch=%0d frame=%h required err1 ch2 frame=%h",
                     ok, err, res_ch, res_frame, model(mk(16'h500)));
        else n_pass++;
        res_ready = 1; @(negedge clk); res_ready = 0;
`else
        hang = 1;
        in_frame[1*FW +: FW] = mk(16'h400);
        in_valid = 4'b0010;
        @(negedge clk);
        in_valid = '0;
        repeat (100) @(negedge clk);
        n_chk++;
        if (res_valid !== 0 || busy !== 1 || err !== 0 || core_start !== 1)
            $display("FAIL no_timeout_wait: rv=%b busy=%b err=%b st=%b required 0/1/0/1",
                     res_valid, busy, err, core_start);
        else n_pass++;
        hang = 0;
        do_reset();
`endif
    endtask

    task automatic test_reset_in_run();
        bit ok;
        in_frame[0 +: FW] = mk(16'h600);
        in_valid = 4'b0001; #1;
        n_chk++;
        if (in_ready !== 4'b0001) $display("FAIL rstrun_grant: in_ready=%b required 0001", in_ready);
        else n_pass++;
        @(negedge clk);
        in_valid = '0;
        @(negedge clk);
        n_chk++;
        if (busy !== 1 || core_start !== 1)
            $display("FAIL rstrun_inrun: busy=%b st=%b required 1/1", busy, core_start);
        else n_pass++;
        rst = 1;
        @(negedge clk);
        n_chk++;
        if (in_ready !== '0 || res_valid !== 0 || res_frame !== '0 || res_ch !== '0 ||
            busy !== 0 || err !== 0 || core_start !== 0 || core_din !== '0)
            $display("FAIL rstrun_outputs: rdy=%b rv=%b rf=%h ch=%0d busy=%b err=%b st=%b din=%h required all zero",
                     in_ready, res_valid, res_frame, res_ch, busy, err, core_start, core_din);
        else n_pass++;
        rst = 0;
        @(negedge clk);
        in_frame[2*FW +: FW] = mk(16'h700);
        in_valid = 4'b0100; #1;
        n_chk++;
        if (in_ready !== 4'b0100) $display("FAIL rstrun_regrant: in_ready=%b required 0100", in_ready);
        else n_pass++;
        @(negedge clk);
        in_valid = '0;
        wait_res(ok);
        n_chk++;
        if (!ok || res_ch !== 2'd2 || res_frame !== model(mk(16'h700)) || err !== 0)
            $display("FAIL rstrun_fresh: ok=%b ch=%0d frame=%h err=%b required ch2 frame=%h err0",
                     ok, res_ch, res_frame, err, model(mk(16'h700)));
        else n_pass++;
        res_ready = 1; @(negedge clk); res_ready = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; in_valid = '0; res_ready = 0; in_frame = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_wrap();
        test_stray_done();
        test_timeout();
        test_reset_in_run();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
